// File: rtl/db_mem_bridge_if.sv
// rtl/db_mem_bridge_if.sv - CPU data-bus and word-memory port bundle for db_mem_bridge
interface db_mem_bridge_if #(
  parameter int unsigned MEM_AW = 30
);
  logic [31:0]       db_addr;
  logic [1:0]        db_access_type;
  logic [31:0]       db_data_out;
  logic [31:0]       db_data_in;
  logic              db_ready;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  // master = the surrounding CPU and memory, slave = the bridge itself
  modport master (
    output db_addr, db_access_type, db_data_out, mem_rdata, mem_ack,
    input  db_data_in, db_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  db_addr, db_access_type, db_data_out, mem_rdata, mem_ack,
    output db_data_in, db_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/db_mem_bridge.sv
// rtl/db_mem_bridge.sv - CPU data-bus to variable-latency req/ack word memory bridge
// Flags misaligned accesses and memory timeouts as one-cycle pulses alongside db_ready.
module db_mem_bridge #(
  parameter int unsigned MEM_AW   = 30,
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  res,
  db_mem_bridge_if.slave        bus,
  output logic                  err_align,
  output logic                  err_timeout,
  output logic [31:0]           err_addr
);
  // Access-type encoding: NONE=0, R=1, W=2, X=3; only NONE and W need decoding here.
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_W    = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] req_addr;

  always_ff @(posedge clk) begin
    if (res) begin
      state           <= IDLE;
      tmo_cnt         <= 8'd0;
      req_addr        <= 32'd0;
      bus.db_ready    <= 1'b0;
      bus.db_data_in  <= 32'd0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= 32'd0;
      err_align       <= 1'b0;
      err_timeout     <= 1'b0;
      err_addr        <= 32'd0;
    end else begin
      bus.db_ready <= 1'b0;
      err_align    <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        // RESP samples too: the CPU already holds its next request there
        IDLE, RESP: begin
          if (bus.db_access_type != ACC_NONE) begin
            req_addr     <= bus.db_addr;
            bus.mem_we   <= (bus.db_access_type == ACC_W);
            bus.mem_addr <= bus.db_addr[MEM_AW+1:2];
            if (bus.db_access_type == ACC_W) begin
              bus.mem_wdata <= bus.db_data_out;
            end
            if (bus.db_addr[1:0] == 2'b00) begin
              state       <= ACCESS;
              bus.mem_req <= 1'b1;
            end else begin
              state          <= RESP;
              bus.db_ready   <= 1'b1;
              bus.db_data_in <= ERR_DATA;
              err_align      <= 1'b1;
              err_addr       <= bus.db_addr;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // ack is checked first so an ack on the final allowed cycle still succeeds
          if (bus.mem_ack) begin
            state        <= RESP;
            bus.mem_req  <= 1'b0;
            bus.db_ready <= 1'b1;
            tmo_cnt      <= 8'd0;
            if (!bus.mem_we) begin
              bus.db_data_in <= bus.mem_rdata;
            end
          end else if (TIMEOUT != 8'd0 && tmo_cnt + 8'd1 == TIMEOUT) begin
            state          <= RESP;
            bus.mem_req    <= 1'b0;
            bus.db_ready   <= 1'b1;
            tmo_cnt        <= 8'd0;
            bus.db_data_in <= ERR_DATA;
            err_timeout    <= 1'b1;
            err_addr       <= req_addr;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
